// File: rtl/umi_arbiter_pkt_if.sv
// rtl/umi_arbiter_pkt_if.sv - request/grant bundle between requesters and the packet arbiter
interface umi_arbiter_pkt_if #(
   parameter int N       = 4,
   parameter int WEIGHTW = 4
);
   logic [1:0]           mode;
   logic [N-1:0]         mask;
   logic [N-1:0]         requests;
   logic [N-1:0]         last;
   logic                 ready;
   logic [N*WEIGHTW-1:0] weights;
   logic [N-1:0]         grants;
   logic                 locked;
   logic                 collision;

   modport master (
      output mode, mask, requests, last, ready, weights,
      input  grants, locked, collision
   );

   modport slave (
      input  mode, mask, requests, last, ready, weights,
      output grants, locked, collision
   );
endinterface

// File: rtl/umi_arbiter_pkt.sv
// rtl/umi_arbiter_pkt.sv - packet-aware N-way arbiter (priority / round robin / weighted round robin)
module umi_arbiter_pkt #(
   parameter int N       = 4,
   parameter int WEIGHTW = 4,
   parameter     TARGET  = "DEFAULT"
) (
   input  logic               clk,
   input  logic               reset,
   umi_arbiter_pkt_if.slave   arb_io
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic {ST_OPEN, ST_LOCKED} state_e;

   state_e               state_q, state_d;
   logic [PW-1:0]        ptr_q, ptr_d;
   logic [PW-1:0]        lock_id_q, lock_id_d;
   logic [WEIGHTW-1:0]   credit_q, credit_d;

   logic [N-1:0]         eligible;
   logic                 pri_hit, rr_hit, sel_hit;
   logic [PW-1:0]        pri_idx, rr_idx, sel_idx, cand;
   int                   idx;
   logic [N-1:0]         grants_int;
   logic                 accept, is_last;

   assign eligible = arb_io.requests & ~arb_io.mask;

   always_comb begin
      pri_hit = 1'b0;
      pri_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            pri_hit = 1'b1;
            pri_idx = PW'(i);
         end
      end
      // Scan downward so the nearest index above ptr overwrites; k == N lands on ptr itself.
      rr_hit = 1'b0;
      rr_idx = '0;
      idx    = 0;
      cand   = '0;
      for (int k = N; k >= 1; k--) begin
         idx = int'(ptr_q) + k;
         if (idx >= N) idx = idx - N;
         cand = PW'(idx);
         if (eligible[cand]) begin
            rr_hit = 1'b1;
            rr_idx = cand;
         end
      end
   end

   always_comb begin
      sel_hit = 1'b0;
      sel_idx = '0;
      if (state_q == ST_LOCKED) begin
         sel_hit = arb_io.requests[lock_id_q];
         sel_idx = lock_id_q;
      end else begin
         case (arb_io.mode)
            2'b01: begin
               sel_hit = rr_hit;
               sel_idx = rr_idx;
            end
            2'b10: begin
               if ((credit_q != '0) && eligible[ptr_q]) begin
                  sel_hit = 1'b1;
                  sel_idx = ptr_q;
               end else begin
                  sel_hit = rr_hit;
                  sel_idx = rr_idx;
               end
            end
            default: begin
               sel_hit = pri_hit;
               sel_idx = pri_idx;
            end
         endcase
      end
      grants_int = '0;
      if (sel_hit && !reset) grants_int = N'(1) << sel_idx;
   end

   assign accept  = arb_io.ready & |(grants_int & arb_io.requests);
   assign is_last = |(grants_int & arb_io.last);

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      lock_id_d = lock_id_q;
      credit_d  = credit_q;
      if (accept) begin
         if (is_last) begin
            state_d = ST_OPEN;
            ptr_d   = sel_idx;
            if (arb_io.mode == 2'b10) begin
               if (sel_idx != ptr_q)
                  credit_d = arb_io.weights[int'(sel_idx)*WEIGHTW +: WEIGHTW];
               else if (credit_q != '0)
                  credit_d = credit_q - 1'b1;
            end else begin
               credit_d = '0;
            end
         end else begin
            state_d   = ST_LOCKED;
            lock_id_d = sel_idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_OPEN;
         lock_id_q <= '0;
         credit_q  <= '0;
         ptr_q     <= PW'(N - 1);
      end else begin
         state_q   <= state_d;
         lock_id_q <= lock_id_d;
         credit_q  <= credit_d;
         ptr_q     <= ptr_d;
      end
   end

   always_comb begin
      arb_io.grants    = grants_int;
      arb_io.locked    = (state_q == ST_LOCKED);
      arb_io.collision = |(eligible & ~grants_int);
   end

endmodule

// File: tb/tb_umi_arbiter_pkt.sv
// tb/tb_umi_arbiter_pkt.sv - directed scoreboard bench for umi_arbiter_pkt
module tb_umi_arbiter_pkt;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   umi_arbiter_pkt_if #(.N(4), .WEIGHTW(4)) arb ();

   umi_arbiter_pkt #(.N(4), .WEIGHTW(4), .TARGET("DEFAULT")) dut (
      .clk    (clk),
      .reset  (reset),
      .arb_io (arb.slave)
   );

   int errors = 0;
   int checks = 0;

   logic [3:0] exp_g_q[$];
   logic       exp_l_q[$];
   logic       exp_c_q[$];
   string      tag_q[$];

   task automatic expect_cycle(input string tag, input logic [3:0] g, input logic l, input logic c);
      logic [3:0] eg;
      logic       el, ec;
      string      t;
      exp_g_q.push_back(g);
      exp_l_q.push_back(l);
      exp_c_q.push_back(c);
      tag_q.push_back(tag);
      @(negedge clk);
      eg = exp_g_q.pop_front();
      el = exp_l_q.pop_front();
      ec = exp_c_q.pop_front();
      t  = tag_q.pop_front();
      checks++;
      assert (arb.grants === eg) else begin
         errors++;
         $error("FAIL %s grants got=%b exp=%b", t, arb.grants, eg);
      end
      checks++;
      assert (arb.locked === el) else begin
         errors++;
         $error("FAIL %s locked got=%b exp=%b", t, arb.locked, el);
      end
      checks++;
      assert (arb.collision === ec) else begin
         errors++;
         $error("FAIL %s collision got=%b exp=%b", t, arb.collision, ec);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset        = 1'b1;
      arb.mode     = 2'b00;
      arb.mask     = 4'b0000;
      arb.requests = 4'b0000;
      arb.last     = 4'b1111;
      arb.ready    = 1'b1;
      arb.weights  = 16'h0000;
      @(posedge clk);
      #1;

      expect_cycle("reset_idle", 4'b0000, 1'b0, 1'b0);
      arb.requests = 4'b1111;
      expect_cycle("reset_gate", 4'b0000, 1'b0, 1'b1);
      reset = 1'b0;

      // fixed priority
      arb.requests = 4'b1010;
      expect_cycle("pri_a", 4'b0010, 1'b0, 1'b1);
      expect_cycle("pri_b", 4'b0010, 1'b0, 1'b1);
      expect_cycle("pri_c", 4'b0010, 1'b0, 1'b1);
      arb.mode     = 2'b11;
      arb.requests = 4'b1100;
      expect_cycle("mode11", 4'b0100, 1'b0, 1'b1);

      // round robin from reset
      reset        = 1'b1;
      arb.mode     = 2'b01;
      arb.requests = 4'b1111;
      expect_cycle("rr_reset", 4'b0000, 1'b0, 1'b1);
      reset = 1'b0;
      expect_cycle("rr_0", 4'b0001, 1'b0, 1'b1);
      expect_cycle("rr_1", 4'b0010, 1'b0, 1'b1);
      expect_cycle("rr_2", 4'b0100, 1'b0, 1'b1);
      expect_cycle("rr_3", 4'b1000, 1'b0, 1'b1);
      expect_cycle("rr_wrap", 4'b0001, 1'b0, 1'b1);
      expect_cycle("rr_pre", 4'b0010, 1'b0, 1'b1);

      // 3-beat packet on requester 2 with a ready stall
      arb.last = 4'b1011;
      expect_cycle("pkt_beat1", 4'b0100, 1'b0, 1'b1);
      arb.ready = 1'b0;
      expect_cycle("pkt_stall1", 4'b0100, 1'b1, 1'b1);
      expect_cycle("pkt_stall2", 4'b0100, 1'b1, 1'b1);
      arb.ready = 1'b1;
      expect_cycle("pkt_beat2", 4'b0100, 1'b1, 1'b1);
      arb.last = 4'b1111;
      expect_cycle("pkt_beat3", 4'b0100, 1'b1, 1'b1);
      expect_cycle("pkt_after", 4'b1000, 1'b0, 1'b1);

      // weighted round robin, weight 2 on requester 2
      reset       = 1'b1;
      arb.mode    = 2'b10;
      arb.weights = 16'h0200;
      expect_cycle("wrr_reset", 4'b0000, 1'b0, 1'b1);
      reset = 1'b0;
      expect_cycle("wrr_0", 4'b0001, 1'b0, 1'b1);
      expect_cycle("wrr_1", 4'b0010, 1'b0, 1'b1);
      expect_cycle("wrr_2a", 4'b0100, 1'b0, 1'b1);
      expect_cycle("wrr_2b", 4'b0100, 1'b0, 1'b1);
      expect_cycle("wrr_2c", 4'b0100, 1'b0, 1'b1);
      expect_cycle("wrr_3", 4'b1000, 1'b0, 1'b1);
      expect_cycle("wrr_wrap", 4'b0001, 1'b0, 1'b1);

      // lock on requester 1 ignores mask and mode, holds through a dropped request
      arb.mode     = 2'b00;
      arb.requests = 4'b0010;
      arb.last     = 4'b0000;
      expect_cycle("lk_start", 4'b0010, 1'b0, 1'b0);
      arb.mask     = 4'b0010;
      arb.requests = 4'b0011;
      expect_cycle("lk_masked", 4'b0010, 1'b1, 1'b1);
      arb.mask = 4'b0000;
      arb.mode = 2'b01;
      expect_cycle("lk_mode", 4'b0010, 1'b1, 1'b1);
      arb.requests = 4'b0001;
      expect_cycle("lk_drop1", 4'b0000, 1'b1, 1'b1);
      expect_cycle("lk_drop2", 4'b0000, 1'b1, 1'b1);

      // reset mid-packet
      reset        = 1'b1;
      arb.requests = 4'b1111;
      arb.last     = 4'b1111;
      expect_cycle("mid_reset", 4'b0000, 1'b1, 1'b1);
      reset = 1'b0;
      expect_cycle("post_reset0", 4'b0001, 1'b0, 1'b1);
      expect_cycle("post_reset1", 4'b0010, 1'b0, 1'b1);
      arb.ready = 1'b0;
      expect_cycle("hold_a", 4'b0100, 1'b0, 1'b1);
      expect_cycle("hold_b", 4'b0100, 1'b0, 1'b1);
      arb.ready = 1'b1;
      expect_cycle("hold_go", 4'b0100, 1'b0, 1'b1);
      expect_cycle("hold_next", 4'b1000, 1'b0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/umi_arbiter_pkt.md
UMI_ARBITER_PKT -- requirements
Module: umi_arbiter_pkt

Interface
REQ-001 Parameter N, default 4: number of requesters, legal range 1..32.
REQ-002 Parameter WEIGHTW, default 4: width of each per-requester weight field.
REQ-003 Parameter TARGET, default "DEFAULT": implementation target selector; no functional effect.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 mode  input  2  arbitration mode: 00 = priority, 01 = round robin, 10 = weighted round robin, 11 = reserved, behaves as 00.
REQ-007 mask  input  N  1 = requester disabled, 0 = enabled.
REQ-008 requests  input  N  per-requester valid.
REQ-009 last  input  N  per-requester end-of-packet marker, qualified by requests.
REQ-010 ready  input  1  downstream accepts the granted beat this cycle.
REQ-011 weights  input  N*WEIGHTW  weight of requester i at bits [i*WEIGHTW +: WEIGHTW].
REQ-012 grants  output  N  one-hot or zero grant vector, combinational from state and inputs.
REQ-013 locked  output  1  registered; 1 while a multi-beat packet holds the arbiter.
REQ-014 collision  output  1  combinational; 1 when any eligible requester is not granted.

Function
REQ-015 eligible = requests & ~mask.
REQ-016 accept = ready & |(grants & requests).
REQ-017 grants SHALL never have more than one bit set.
REQ-018 Unlocked, mode 00/11: grant the lowest-index eligible requester.
REQ-019 Unlocked, mode 01: grant the first eligible requester at index strictly above pointer ptr, wrapping modulo N; ptr may win only if it is the sole eligible requester.
REQ-020 Unlocked, mode 10: if the credit counter is nonzero and requester ptr is eligible, grant ptr; otherwise select as in mode 01.
REQ-021 Locked: grants = onehot(lock_id) & requests; mask and mode are ignored.
REQ-022 Locked with requests[lock_id] = 0: grants = 0 and lock is retained (no interleaving).
REQ-023 On accept with last = 0 for the winner: locked <= 1, lock_id <= winner.
REQ-024 On accept with last = 1: locked <= 0 (packet end).
REQ-025 On packet end, ptr <= winner in all modes.
REQ-026 On packet end in mode 10:
  - if winner != previous ptr, credit <= weights[winner];
  - else credit <= credit - 1, saturating at 0.
  - A requester therefore wins up to weight+1 consecutive packets.
REQ-027 In modes other than 10, credit is forced to 0 on packet end.
REQ-028 No accept: ptr, credit, locked and lock_id are held.
REQ-029 ready = 0 SHALL NOT alter grants within the cycle; grant is stable until accept or until the request drops.
REQ-030 Mode changes take effect only while unlocked, on the next cycle's selection.
REQ-031 collision = |(eligible & ~grants), evaluated in the same cycle as grants.
REQ-032 N = 1: grants = requests & ~mask while unlocked; the lock rules still apply.
REQ-033 A single-beat packet (last = 1 on the first beat) never sets locked.

Reset
REQ-034 While reset = 1 at a rising edge:
  - locked <= 0;
  - lock_id <= 0;
  - credit <= 0;
  - ptr <= N-1, so requester 0 wins first in round robin.
REQ-035 During reset, grants SHALL be 0; a packet in flight is abandoned, and the arbiter is unlocked on the first cycle after reset.
REQ-036 Reset overrides a simultaneous accept.

Verification
REQ-037 N=4, mode=00, requests=1010, last=1111, ready=1 -> grants=0010 every cycle; collision=1.
REQ-038 N=4, mode=01, requests=1111, last=1111, ready=1 from reset -> grants sequence 0001,0010,0100,1000,0001.
REQ-039 N=4, mode=01: requester 2 sends a 3-beat packet (last on beat 3) while requests=1111.
  - Required: grants=0100 for 3 accepts; locked=1 after beats 1-2; then grants=1000.
  - ready=0 for 2 cycles mid-packet holds grants=0100.
REQ-040 N=4, mode=10, weights={0,0,2,0}, requests=1111, single-beat packets -> grants 0001,0010,0100,0100,0100,1000,0001.
REQ-041 Locked on requester 1: mask=0010 -> grants still 0010; requests[1]=0 -> grants=0000 and locked stays 1.
REQ-042 Reset asserted mid-packet (locked=1) -> next cycle locked=0, grants follow unlocked selection from ptr=N-1.
